// File: rtl/jpeg_output_yuv2rgb_if.sv
// Sample-buffer and pixel-output handshake bundle for the YCbCr to RGB stage.
// The slave modport is the converter; the master modport is the surrounding
// buffers/sink that supply samples and accept pixels.
interface jpeg_output_yuv2rgb_if;
    logic [31:0] y_data_i;
    logic        y_valid_i;
    logic        y_pop_o;
    logic [31:0] cb_data_i;
    logic        cb_valid_i;
    logic        cb_pop_o;
    logic [31:0] cr_data_i;
    logic        cr_valid_i;
    logic        cr_pop_o;
    logic [31:0] data_o;
    logic        valid_o;
    logic        accept_i;

    modport slave (
        input  y_data_i, y_valid_i, cb_data_i, cb_valid_i, cr_data_i, cr_valid_i, accept_i,
        output y_pop_o, cb_pop_o, cr_pop_o, data_o, valid_o
    );

    modport master (
        output y_data_i, y_valid_i, cb_data_i, cb_valid_i, cr_data_i, cr_valid_i, accept_i,
        input  y_pop_o, cb_pop_o, cr_pop_o, data_o, valid_o
    );
endinterface

// File: rtl/jpeg_output_yuv2rgb.sv
// YCbCr to RGB colour conversion: joins one Y/Cb/Cr sample, converts in fixed
// point over two pipeline stages and presents one packed pixel per cycle.
// Optional macro JPEG_YUV2RGB_RGB565_EN selects RGB565 packing instead of RGB888.
module jpeg_output_yuv2rgb (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic                  mono_i,
    jpeg_output_yuv2rgb_if.slave  bus,
    output logic [31:0]           pixel_count_o
);

    // Output pixel for one channel before clamping: Y + round(p/256) + 128.
    function automatic logic signed [27:0] chan_sum(input logic signed [27:0] y,
                                                    input logic signed [27:0] p);
        logic signed [27:0] t;
        t = p + 28'sd128;
        return y + (t >>> 8) + 28'sd128;
    endfunction

    // Saturate a signed channel value into 0..255.
    function automatic logic [7:0] clamp8(input logic signed [27:0] v);
        if (v < 28'sd0)
            return 8'h00;
        else if (v > 28'sd255)
            return 8'hFF;
        else
            return v[7:0];
    endfunction

    logic                w_en;
    logic                w_join;
    logic signed [27:0]  w_y;
    logic signed [27:0]  w_cb;
    logic signed [27:0]  w_cr;
    logic [7:0]          w_r;
    logic [7:0]          w_g;
    logic [7:0]          w_b;
    logic [31:0]         w_pix;
    logic                w_unused_hi;

    logic signed [27:0]  r_y_p1;
    logic signed [27:0]  r_pr_p1;
    logic signed [27:0]  r_pg_p1;
    logic signed [27:0]  r_pb_p1;
    logic                r_valid_p1;
    logic [31:0]         r_data_p2;
    logic                r_valid_p2;
    logic [31:0]         r_count;

    // Upper halves of the sample words carry nothing for this stage.
    assign w_unused_hi = ^{bus.y_data_i[31:16], bus.cb_data_i[31:16], bus.cr_data_i[31:16]};

    // The whole pipeline advances together; a stalled output freezes both stages.
    // Gating with rst_ni keeps the pops low for the full duration of reset.
    assign w_en   = !r_valid_p2 || bus.accept_i;
    assign w_join = rst_ni && w_en && bus.y_valid_i &&
                    (mono_i || (bus.cb_valid_i && bus.cr_valid_i)) && !flush_i;

    assign bus.y_pop_o  = w_join;
    assign bus.cb_pop_o = w_join && !mono_i;
    assign bus.cr_pop_o = w_join && !mono_i;

    assign w_y  = {{12{bus.y_data_i[15]}}, bus.y_data_i[15:0]};
    assign w_cb = mono_i ? 28'sd0 : {{12{bus.cb_data_i[15]}}, bus.cb_data_i[15:0]};
    assign w_cr = mono_i ? 28'sd0 : {{12{bus.cr_data_i[15]}}, bus.cr_data_i[15:0]};

    // ---- stage 1: chroma products ----
    // Register luma and the chroma contributions whenever the pipeline advances.
    always_ff @(posedge clk_i) begin
        if (w_en) begin
            r_y_p1  <= w_y;
            r_pr_p1 <= 28'sd359 * w_cr;
            r_pg_p1 <= -(28'sd88 * w_cb) - (28'sd183 * w_cr);
            r_pb_p1 <= 28'sd454 * w_cb;
        end
    end

    // ---- stage 2: sum, clamp, pack ----
    assign w_r = clamp8(chan_sum(r_y_p1, r_pr_p1));
    assign w_g = clamp8(chan_sum(r_y_p1, r_pg_p1));
    assign w_b = clamp8(chan_sum(r_y_p1, r_pb_p1));

`ifdef JPEG_YUV2RGB_RGB565_EN
    assign w_pix = {16'h0000, w_r[7:3], w_g[7:2], w_b[7:3]};
`else
    assign w_pix = {8'h00, w_r, w_g, w_b};
`endif

    // Output pixel register; holds while the sink is not accepting.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_data_p2 <= 32'h0;
        else if (w_en)
            r_data_p2 <= w_pix;
    end

    // Valid bits travel with the data; flush discards anything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_valid_p1 <= 1'b0;
            r_valid_p2 <= 1'b0;
        end else if (flush_i) begin
            r_valid_p1 <= 1'b0;
            r_valid_p2 <= 1'b0;
        end else if (w_en) begin
            r_valid_p1 <= w_join;
            r_valid_p2 <= r_valid_p1;
        end
    end

    // Count pixels handed to the sink since reset or the last flush.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_count <= 32'h0;
        else if (flush_i)
            r_count <= 32'h0;
        else if (r_valid_p2 && bus.accept_i)
            r_count <= r_count + 32'd1;
    end

    assign bus.data_o    = r_data_p2;
    assign bus.valid_o   = r_valid_p2;
    assign pixel_count_o = r_count;

endmodule

// File: doc/jpeg_output_yuv2rgb.md
# jpeg_output_yuv2rgb

- Colour-conversion stage directly downstream of the output Y, Cb and Cr sample buffers.
- Joins one sample from each buffer, converts YCbCr to RGB888 in fixed point, and presents one packed pixel per cycle on a valid/accept handshake toward the output port.
- Two-stage pipeline; full throughput; global stall under backpressure; monochrome bypass for single-component images.

## Interface
Parameters: none.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous pipeline/counter clear (new image)
- mono_i  in  1  1 = greyscale image: Cb/Cr treated as 0 and never popped
- y_data_i  in  32  Y sample, signed, [15:0] used, [31:16] ignored
- y_valid_i  in  1  Y sample available
- y_pop_o  out  1  consume Y sample this cycle
- cb_data_i / cb_valid_i / cb_pop_o  in/in/out  32/1/1  same contract for Cb
- cr_data_i / cr_valid_i / cr_pop_o  in/in/out  32/1/1  same contract for Cr
- data_o  out  32  pixel {8'h00,R,G,B} (see Configuration)
- valid_o  out  1  data_o valid
- accept_i  in  1  sink takes pixel when valid_o && accept_i
- pixel_count_o  out  32  pixels accepted since reset/flush

## Operation
- Samples are not level-shifted (nominal -128..127); +128 is applied after conversion.
- Advance enable: en = !valid_o || accept_i.
- Join condition: join = en && y_valid_i && (mono_i || (cb_valid_i && cr_valid_i)) && !flush_i.
- Pops (combinational): y_pop_o = join; cb_pop_o = cr_pop_o = join && !mono_i. Never pop without a matching valid.
- Stage 1 (registered when en): Y, Cb, Cr each sign-extended from [15:0] to 28 bits; Cb, Cr forced to 0 when mono_i. Register the products:
  - pr = 359·Cr
  - pg = -88·Cb - 183·Cr
  - pb = 454·Cb
  - s1_valid <= join.
- Stage 2 (registered when en). For each channel c:
  - v = Y + ((p + 128) >>> 8) + 128, arithmetic shift, 28-bit signed.
  - Clamp: v < 0 → 0; v > 255 → 255; else v[7:0].
  - valid_o <= s1_valid.
- While en = 0, all stage registers and valids hold; data_o is stable while valid_o && !accept_i.
- pixel_count_o increments by 1 on each valid_o && accept_i; 32-bit wrap 0xFFFFFFFF → 0.
- flush_i, synchronous, highest priority:
  - s1_valid, valid_o and pixel_count_o cleared next cycle.
  - No pops that cycle.
  - Any in-flight pixel is discarded.
- mono_i is sampled per join; it is stable for a whole image.

## Timing
- Reset (rst_ni low, asynchronous): valid_o = 0, s1_valid = 0, data_o = 0, pixel_count_o = 0, all pops 0 (combinational from valids = 0).
- Latency: pop in cycle N → valid_o in cycle N+2.
- Throughput: 1 pixel/cycle with accept_i held high and inputs always valid.
- Backpressure: valid_o && !accept_i stalls both stages and deasserts all pops the same cycle.
- Accept and join in the same cycle are legal: the pipeline shifts and the count increments.
- Missing component (e.g. Cb valid, Cr not): no pops at all. A partial join is never performed.
- Reset asserted mid-pipeline: in-flight pixels are lost; pops drop immediately.

## Configuration
- JPEG_YUV2RGB_RGB565_EN defined: data_o = {16'h0000, R[7:3], G[7:2], B[7:3]}, produced by truncation after clamp. Pipeline, latency and handshake are unchanged.
- JPEG_YUV2RGB_RGB565_EN undefined (default): data_o = {8'h00, R, G, B}.

## Test plan
- Y=0, Cb=0, Cr=0, accept_i=1 → pops in cycle N, valid_o in N+2, data_o = 0x00808080, pixel_count_o = 1.
- Y=127, Cb=0, Cr=127 → data_o = 0x00FFA4FF (R clamped high, G=164). Y=Cb=Cr=-128 → 0x00008800 (R, B clamped low, G=136).
- mono_i=1, Y=50, cb_valid_i=cr_valid_i=0 → y_pop_o=1, cb_pop_o=cr_pop_o=0, data_o = 0x00B2B2B2.
- Stream 8 pixels, accept_i low for 3 cycles mid-stream:
  - data_o stable while stalled.
  - No pops while stalled.
  - All 8 pixels delivered in order, none dropped or duplicated.
  - pixel_count_o = 8.
- cb_valid_i low, y/cr valid → no pops for any component. Raise cb_valid_i → single join, one pixel out.
- flush_i with two pixels in flight → valid_o = 0 and pixel_count_o = 0 next cycle. rst_ni low asynchronously mid-stream → valid_o drops without a clock edge.
- With JPEG_YUV2RGB_RGB565_EN: Y=Cb=Cr=0 → data_o = 0x00008410.
